// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the UART MMIO bridge: register offsets, STATUS/CTRL
// bit positions and the CTRL register layout.
package uart_mmio_pkg;

  // Byte offsets of the four registers inside the window
  localparam logic [3:0] OFS_RXDATA = 4'h0;
  localparam logic [3:0] OFS_TXDATA = 4'h4;
  localparam logic [3:0] OFS_STATUS = 4'h8;
  localparam logic [3:0] OFS_CTRL   = 4'hC;

  // STATUS bit positions
  localparam int ST_RX_NEMPTY    = 0;
  localparam int ST_RX_FULL      = 1;
  localparam int ST_TX_FULL      = 2;
  localparam int ST_TX_EMPTY     = 3;
  localparam int ST_RX_OVERRUN   = 4;
  localparam int ST_PARITY_ERR   = 5;
  localparam int ST_TX_OVERFLOW  = 6;
  localparam int ST_RX_COUNT_LSB = 8;

  // CTRL bit positions
  localparam int CTRL_RX_FLUSH  = 0;
  localparam int CTRL_TX_FLUSH  = 1;
  localparam int CTRL_RX_IRQ_EN = 2;
  localparam int CTRL_TX_IRQ_EN = 3;

  // CTRL register layout, bit 0 is the last member
  typedef struct packed {
    logic tx_irq_en;
    logic rx_irq_en;
    logic tx_flush;
    logic rx_flush;
  } ctrl_t;

  // Build the CTRL readback value; the flush bits are pulses and always read 0
  function automatic ctrl_t ctrl_readback(input logic rx_irq_en, input logic tx_irq_en);
    ctrl_t c;
    c = '0;
    c.rx_irq_en = rx_irq_en;
    c.tx_irq_en = tx_irq_en;
    return c;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO. Occupancy is tracked by an explicit counter so full and
// empty never depend on pointer comparison. A pop on empty and a push on full
// (without a same-cycle pop) are ignored. Flush clears pointers and count and
// overrides any push or pop in the same cycle. Storage is not reset.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is accepted only when a pop frees a slot this cycle
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy update; flush wins over push and pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Data storage write; a flushed push is discarded
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_mmio_bridge.sv
// Memory-mapped UART register bank: RX and TX FIFOs between the CPU bus and
// the UART engines, sticky error flags, flush control and a level interrupt.
// Read data is combinational from the address and current state.
module uart_mmio_bridge
  import uart_mmio_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(32'h10010030),
  parameter int                    FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] WD,
  input  logic                  we,
  input  logic                  re,
  output logic [DATA_WIDTH-1:0] RD,
  output logic                  hit,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_byte,
  input  logic                  rx_parity_err,
  output logic [7:0]            tx_byte,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  irq
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [ADDR_WIDTH-1:0] ofs;
  logic [3:0]            reg_ofs;
  logic                  sel_rx;
  logic                  sel_tx;
  logic                  sel_status;
  logic                  sel_ctrl;

  logic                  rx_pop_req;
  logic                  rx_pop;
  logic                  rx_flush;
  logic [7:0]            rx_dout;
  logic [CNT_W-1:0]      rx_count;
  logic                  rx_full;
  logic                  rx_empty;

  logic                  tx_push;
  logic                  tx_pop;
  logic                  tx_flush;
  logic [7:0]            tx_dout;
  logic [CNT_W-1:0]      tx_count_unused;
  logic                  tx_full;
  logic                  tx_empty;

  logic                  rx_irq_en_q;
  logic                  tx_irq_en_q;
  logic                  rx_overrun_q;
  logic                  parity_err_q;
  logic                  tx_overflow_q;

  logic                  status_rd;
  logic                  ctrl_wr;
  ctrl_t                 wd_ctrl;
  ctrl_t                 rd_ctrl;
  logic [15:0]           status16;
  logic [DATA_WIDTH-1:0] rd_c;

  logic                  set_overrun;
  logic                  set_parity;
  logic                  set_overflow;
  logic                  unused_wd;

  // Window decode: subtraction wraps addresses below the base out of range
  assign ofs        = A - BASE_ADDR;
  assign hit        = (ofs[ADDR_WIDTH-1:4] == '0) && (ofs[1:0] == 2'b00);
  assign reg_ofs    = ofs[3:0];
  assign sel_rx     = hit && (reg_ofs == OFS_RXDATA);
  assign sel_tx     = hit && (reg_ofs == OFS_TXDATA);
  assign sel_status = hit && (reg_ofs == OFS_STATUS);
  assign sel_ctrl   = hit && (reg_ofs == OFS_CTRL);

  assign wd_ctrl    = ctrl_t'(WD[3:0]);
  assign ctrl_wr    = we && sel_ctrl;
  assign rx_flush   = ctrl_wr && wd_ctrl.rx_flush;
  assign tx_flush   = ctrl_wr && wd_ctrl.tx_flush;
  assign status_rd  = re && sel_status;

  assign rx_pop_req = re && sel_rx;
  assign rx_pop     = rx_pop_req && !rx_empty;
  assign tx_push    = we && sel_tx;
  assign tx_pop     = tx_valid && tx_ready;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_valid),
    .pop   (rx_pop_req),
    .flush (rx_flush),
    .din   (rx_byte),
    .dout  (rx_dout),
    .count (rx_count),
    .full  (rx_full),
    .empty (rx_empty)
  );

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .pop   (tx_pop),
    .flush (tx_flush),
    .din   (WD[7:0]),
    .dout  (tx_dout),
    .count (tx_count_unused),
    .full  (tx_full),
    .empty (tx_empty)
  );

  // Storage is not reset, so the head byte is masked while the FIFO is empty
  assign tx_valid = !tx_empty;
  assign tx_byte  = tx_empty ? 8'h00 : tx_dout;

  // Error events; a pop in the same cycle makes room so no overrun/overflow
  assign set_overrun  = rx_valid && rx_full && !rx_pop;
  assign set_parity   = rx_valid && rx_parity_err;
  assign set_overflow = tx_push && tx_full && !tx_pop;

  // Sticky flags: a STATUS read clears them unless a new event lands the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_overrun_q  <= 1'b0;
      parity_err_q  <= 1'b0;
      tx_overflow_q <= 1'b0;
    end else begin
      rx_overrun_q  <= set_overrun  || (rx_overrun_q  && !status_rd);
      parity_err_q  <= set_parity   || (parity_err_q  && !status_rd);
      tx_overflow_q <= set_overflow || (tx_overflow_q && !status_rd);
    end
  end

  // Interrupt enables; flush bits are pulses and are not stored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_irq_en_q <= 1'b0;
      tx_irq_en_q <= 1'b0;
    end else if (ctrl_wr) begin
      rx_irq_en_q <= wd_ctrl.rx_irq_en;
      tx_irq_en_q <= wd_ctrl.tx_irq_en;
    end
  end

  assign rd_ctrl = ctrl_readback(rx_irq_en_q, tx_irq_en_q);

  // STATUS word assembly
  always_comb begin
    status16                                = '0;
    status16[ST_RX_NEMPTY]                  = !rx_empty;
    status16[ST_RX_FULL]                    = rx_full;
    status16[ST_TX_FULL]                    = tx_full;
    status16[ST_TX_EMPTY]                   = tx_empty;
    status16[ST_RX_OVERRUN]                 = rx_overrun_q;
    status16[ST_PARITY_ERR]                 = parity_err_q;
    status16[ST_TX_OVERFLOW]                = tx_overflow_q;
    status16[ST_RX_COUNT_LSB +: 8]          = 8'(rx_count);
  end

  // Read-data mux; TXDATA and out-of-window addresses read as zero
  always_comb begin
    rd_c = '0;
    if (hit) begin
      case (reg_ofs)
        OFS_RXDATA: rd_c[7:0]  = rx_empty ? 8'h00 : rx_dout;
        OFS_STATUS: rd_c[15:0] = status16;
        OFS_CTRL: begin
          rd_c[CTRL_TX_IRQ_EN] = rd_ctrl.tx_irq_en;
          rd_c[CTRL_RX_IRQ_EN] = rd_ctrl.rx_irq_en;
          rd_c[CTRL_TX_FLUSH]  = rd_ctrl.tx_flush;
          rd_c[CTRL_RX_FLUSH]  = rd_ctrl.rx_flush;
        end
        default:    rd_c = '0;
      endcase
    end
  end

  assign RD = rd_c;

  // Level interrupt built only from registered state, never from A
  assign irq = (rx_irq_en_q && !rx_empty) ||
               (tx_irq_en_q && tx_empty) ||
               (rx_irq_en_q && (rx_overrun_q || parity_err_q));

  assign unused_wd = ^WD[DATA_WIDTH-1:8];

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Bench for uart_mmio_bridge: directed scenarios followed by random traffic,
// checked by a queue-based scoreboard against a behavioural model.
module tb_uart_mmio_bridge;

  localparam int          DEPTH = 8;
  localparam logic [31:0] BASE  = 32'h10010030;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] A;
  logic [31:0] WD;
  logic        we;
  logic        re;
  logic [31:0] RD;
  logic        hit;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        rx_parity_err;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready;
  logic        irq;

  always #5 clk = ~clk;

  uart_mmio_bridge #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .A             (A),
    .WD            (WD),
    .we            (we),
    .re            (re),
    .RD            (RD),
    .hit           (hit),
    .rx_valid      (rx_valid),
    .rx_byte       (rx_byte),
    .rx_parity_err (rx_parity_err),
    .tx_byte       (tx_byte),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .irq           (irq)
  );

  int vectors    = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] rd;
    string       name;
  } rd_exp_t;

  typedef struct {
    logic       hit;
    logic       irq;
    logic       txv;
    logic [7:0] txb;
  } cyc_exp_t;

  rd_exp_t    rd_q[$];
  cyc_exp_t   cyc_q[$];
  logic [7:0] sb_tx[$];

  // Behavioural model: plain byte queues plus flag bits
  logic [7:0] m_rx[$];
  logic [7:0] m_tx[$];
  bit         m_ovr, m_par, m_txo, m_rxie, m_txie;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (off < 32'd16) && (off[1:0] == 2'b00);
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    int n;
    n    = m_rx.size();
    s    = 32'h0;
    s[0] = (n > 0);
    s[1] = (n == DEPTH);
    s[2] = (m_tx.size() == DEPTH);
    s[3] = (m_tx.size() == 0);
    s[4] = m_ovr;
    s[5] = m_par;
    s[6] = m_txo;
    s[15:8] = n[7:0];
    return s;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    if (!m_hit(a)) return 32'h0;
    case (off[3:0])
      4'h0:    return (m_rx.size() > 0) ? {24'h0, m_rx[0]} : 32'h0;
      4'h8:    return m_status();
      4'hC:    return {28'h0, m_txie, m_rxie, 2'b00};
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit m_irq();
    return (m_rxie && m_rx.size() > 0) || (m_txie && m_tx.size() == 0) ||
           (m_rxie && (m_ovr || m_par));
  endfunction

  // Apply one clock edge worth of the register-map rules to the model
  function automatic void m_update();
    logic [31:0] off;
    bit h, rx_pop, st_rd, tx_push, tx_pop, ctrl_wr, rxf, txf;
    int nrx, ntx;
    off     = A - BASE;
    h       = m_hit(A);
    nrx     = m_rx.size();
    ntx     = m_tx.size();
    rx_pop  = re && h && off[3:0] == 4'h0 && nrx > 0;
    st_rd   = re && h && off[3:0] == 4'h8;
    tx_push = we && h && off[3:0] == 4'h4;
    tx_pop  = tx_ready && ntx > 0;
    ctrl_wr = we && h && off[3:0] == 4'hC;
    rxf     = ctrl_wr && WD[0];
    txf     = ctrl_wr && WD[1];

    m_ovr = (rx_valid && nrx == DEPTH && !rx_pop) || (m_ovr && !st_rd);
    m_par = (rx_valid && rx_parity_err) || (m_par && !st_rd);
    m_txo = (tx_push && ntx == DEPTH && !tx_pop) || (m_txo && !st_rd);

    if (rxf) m_rx.delete();
    else begin
      if (rx_pop) void'(m_rx.pop_front());
      if (rx_valid && (nrx < DEPTH || rx_pop)) m_rx.push_back(rx_byte);
    end

    if (txf) begin
      m_tx.delete();
      sb_tx.delete();
    end else begin
      if (tx_pop) void'(m_tx.pop_front());
      if (tx_push && (ntx < DEPTH || tx_pop)) begin
        m_tx.push_back(WD[7:0]);
        sb_tx.push_back(WD[7:0]);
      end
    end

    if (ctrl_wr) begin
      m_rxie = WD[2];
      m_txie = WD[3];
    end
  endfunction

  function automatic void m_reset();
    m_rx.delete();
    m_tx.delete();
    sb_tx.delete();
    rd_q.delete();
    cyc_q.delete();
    m_ovr = 0; m_par = 0; m_txo = 0; m_rxie = 0; m_txie = 0;
  endfunction

  // Issue expectations for the current inputs, then advance one clock
  task automatic step(input string nm);
    cyc_exp_t c;
    rd_exp_t  e;
    c.hit = m_hit(A);
    c.irq = m_irq();
    c.txv = (m_tx.size() > 0);
    c.txb = c.txv ? m_tx[0] : 8'h00;
    cyc_q.push_back(c);
    if (re && m_hit(A)) begin
      e.rd   = m_read(A);
      e.name = nm;
      rd_q.push_back(e);
    end
    @(posedge clk);
    m_update();
    #1;
  endtask

  task automatic idle_in();
    A = 32'h0; WD = 32'h0; we = 0; re = 0;
    rx_valid = 0; rx_byte = 8'h00; rx_parity_err = 0; tx_ready = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      idle_in();
      step("idle");
    end
  endtask

  task automatic cpu_rd(input logic [3:0] o, input string nm);
    idle_in(); A = BASE + {28'h0, o}; re = 1; step(nm); idle_in();
  endtask

  task automatic cpu_wr(input logic [3:0] o, input logic [31:0] d, input string nm);
    idle_in(); A = BASE + {28'h0, o}; WD = d; we = 1; step(nm); idle_in();
  endtask

  task automatic rx_in(input logic [7:0] b, input bit p);
    idle_in(); rx_valid = 1; rx_byte = b; rx_parity_err = p; step("rx_in"); idle_in();
  endtask

  task automatic do_reset();
    rst = 1;
    m_reset();
    #1;
    check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  // Scoreboard monitor: compares whenever the DUT presents something
  always @(negedge clk) begin
    cyc_exp_t c;
    rd_exp_t  e;
    if (!rst) begin
      if (cyc_q.size() > 0) begin
        c = cyc_q.pop_front();
        check("hit", {31'h0, hit}, {31'h0, c.hit});
        check("irq", {31'h0, irq}, {31'h0, c.irq});
        check("tx_valid", {31'h0, tx_valid}, {31'h0, c.txv});
        check("tx_byte", {24'h0, tx_byte}, {24'h0, c.txb});
      end
      if (re && hit) begin
        if (rd_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_read: RD %h with no expectation", RD);
        end else begin
          e = rd_q.pop_front();
          check(e.name, RD, e.rd);
        end
      end
      if (tx_valid && tx_ready) begin
        if (sb_tx.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL tx_xfer: byte %h with no expected byte", tx_byte);
        end else begin
          check("tx_xfer", {24'h0, tx_byte}, {24'h0, sb_tx.pop_front()});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    int op;
    rst = 1;
    idle_in();
    m_reset();
    repeat (3) @(posedge clk);
    #1 rst = 0;

    // Reset state
    cpu_rd(4'h8, "reset_status");

    // Ordered RX readout and empty read
    rx_in(8'h41, 0); rx_in(8'h42, 0); rx_in(8'h43, 0);
    cpu_rd(4'h8, "rx3_status");
    for (int i = 0; i < 4; i++) cpu_rd(4'h0, "rx_abc");
    cpu_rd(4'h8, "rx0_status");

    // Overrun: ten bytes into eight slots
    for (int i = 0; i < 10; i++) rx_in(8'h60 + 8'(i), 0);
    cpu_rd(4'h8, "ovr_status1");
    cpu_rd(4'h8, "ovr_status2");
    for (int i = 0; i < 8; i++) cpu_rd(4'h0, "ovr_drain");

    // TX buffering and drain
    cpu_wr(4'h4, 32'h55, "tx_w1");
    cpu_wr(4'h4, 32'hAA, "tx_w2");
    idle(1);
    for (int i = 0; i < 2; i++) begin
      idle_in(); tx_ready = 1; step("tx_drain");
    end
    cpu_rd(4'h8, "tx_empty_status");

    // Full RX with simultaneous push and pop
    for (int i = 0; i < 8; i++) rx_in(8'h80 + 8'(i), 0);
    idle_in(); A = BASE; re = 1; rx_valid = 1; rx_byte = 8'h99; step("full_pushpop");
    idle_in();
    cpu_rd(4'h8, "full_pp_status");
    for (int i = 0; i < 8; i++) cpu_rd(4'h0, "full_pp_drain");

    // Parity sticky and irq with flush
    rx_in(8'h21, 1);
    cpu_wr(4'hC, 32'h4, "ctrl_w4");
    idle(1);
    cpu_rd(4'h8, "par_status");
    cpu_wr(4'hC, 32'h5, "ctrl_w5");
    idle(1);
    cpu_rd(4'hC, "ctrl_rd");
    cpu_wr(4'hC, 32'h8, "ctrl_txie");
    idle(1);
    cpu_wr(4'hC, 32'h0, "ctrl_off");

    // Reset in the middle of a TX drain
    for (int i = 0; i < 3; i++) cpu_wr(4'h4, 32'h30 + 32'(i), "tx_pre_rst");
    idle_in(); tx_ready = 1; step("tx_pre_rst_drain");
    do_reset();
    cpu_rd(4'h8, "post_rst_status");

    // Random traffic
    for (int k = 0; k < 1500; k++) begin
      idle_in();
      rx_valid      = ($urandom_range(0, 2) == 0);
      rx_byte       = 8'($urandom);
      rx_parity_err = ($urandom_range(0, 15) == 0);
      tx_ready      = ($urandom_range(0, 2) == 0);
      WD            = $urandom;
      op            = $urandom_range(0, 11);
      case (op)
        0, 1, 2: begin A = BASE; re = 1; end
        3:       begin A = BASE + 32'h8; re = 1; end
        4:       begin A = BASE + 32'hC; re = 1; end
        5:       begin A = BASE + 32'h4; re = 1; end
        6, 7:    begin A = BASE + 32'h4; we = 1; end
        8:       begin
                   A = BASE + 32'hC; we = 1;
                   WD[1:0] = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
                 end
        9:       begin A = BASE + (($urandom_range(0, 1) == 0) ? 32'h0 : 32'h8); we = 1; end
        10:      begin
                   r = $urandom_range(0, 3);
                   case (r)
                     0: A = BASE - 32'h4;
                     1: A = BASE + 32'h10;
                     2: A = BASE + 32'h1;
                     default: A = BASE + 32'h6;
                   endcase
                   if ($urandom_range(0, 1) == 0) re = 1; else we = 1;
                 end
        default: ;
      endcase
      step("rnd");
    end

    idle(2);
    vectors++;
    if (rd_q.size() != 0) begin
      miscompares++;
      $display("FAIL pending_reads: got %0d unchecked expected 0", rd_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
